mm_bus_arbiter: RTL

Shares the external memory-mapped bus (addresses with `addr[15:13] != 0`) between the CPU and one secondary master, such as a debug loader or a DMA engine. The CPU has no stall input, so the CPU port is a zero-wait combinational pass-through with absolute priority. The secondary master uses a req/ack handshake and is served only in cycles where the CPU is not accessing the bus. The block sits between the CPU's `mm_re`/`mm_we`/`addr`/`wdata`/`rdata` pins and the peripheral decode logic.

---
 rtl/mm_bus_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mm_bus_arbiter.sv
// Two-master arbiter for the external memory-mapped bus: the CPU passes straight through with
// absolute priority, and a secondary req/ack master is served in CPU-free cycles.
module mm_bus_arbiter #(
    parameter int STARVE_LIMIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_re,
    input  logic        cpu_we,
    output logic [15:0] cpu_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [15:0] m1_rdata,
    output logic        m1_starved,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic        bus_re,
    output logic        bus_we,
    input  logic [15:0] bus_rdata,
    output logic        bus_owner
);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_DONE} state_t;

    localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(STARVE_LIMIT);

    state_t             r_state, w_next;
    logic               r_we, r_err, r_starved;
    logic [15:0]        r_addr, r_wdata, r_rdata;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_cpu, w_ext, w_cnt_max;
    logic [CNT_W:0]     w_cnt_inc;

    assign w_cpu     = cpu_re | cpu_we;
    assign w_ext     = |m1_addr[15:13];
    assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_cnt_max = &r_cnt;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (m1_req) w_next = w_ext ? S_PEND : S_DONE;
            S_PEND: if (!w_cpu) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // CPU always wins the bus; the secondary master only drives it from PEND in a free cycle.
    always_comb begin
        bus_addr  = 16'h0000;
        bus_wdata = 16'h0000;
        bus_re    = 1'b0;
        bus_we    = 1'b0;
        bus_owner = 1'b0;
        if (w_cpu) begin
            bus_addr  = cpu_addr;
            bus_wdata = cpu_wdata;
            bus_re    = cpu_re;
            bus_we    = cpu_we;
        end else if (r_state == S_PEND) begin
            bus_addr  = r_addr;
            bus_wdata = r_wdata;
            bus_re    = ~r_we;
            bus_we    = r_we;
            bus_owner = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_starved <= 1'b0;
            r_addr    <= 16'h0000;
            r_wdata   <= 16'h0000;
            r_rdata   <= 16'h0000;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (m1_req) begin
                    r_we    <= m1_we;
                    r_addr  <= m1_addr;
                    r_wdata <= m1_wdata;
                    r_err   <= ~w_ext;
                end
                S_PEND: if (w_cpu) begin
                    if (!w_cnt_max) r_cnt <= w_cnt_inc[CNT_W-1:0];
                    if (w_cnt_inc >= LIMIT) r_starved <= 1'b1;
                end else if (!r_we) begin
                    r_rdata <= bus_rdata;
                end
                S_DONE: begin
                    r_cnt     <= '0;
                    r_starved <= 1'b0;
                    r_err     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign cpu_rdata  = bus_rdata;
    assign m1_ack     = (r_state == S_DONE);
    assign m1_err     = m1_ack & r_err;
    assign m1_rdata   = r_rdata;
    assign m1_starved = r_starved;

endmodule
